axis_stream_arbiter: RTL
========================

Name: axis_stream_arbiter

Overview:
- Parametrised N-input to 1-output AXI-Stream arbiter and mux; the generalised successor of the two-input fixed-priority stream merger.
- Adds selectable fixed-priority or round-robin arbitration, optional packet locking on TLAST, and a source-index sideband.
- A registered 2-entry skid output stage sustains full throughput.
- Sits between parallel producer kernels and a single downstream stream consumer.

Parameters:
- NUM_IN, 4, number of input streams (2..16).
- IN_WIDTH, 16, per-input TDATA width.
- OUT_WIDTH, 32, output TDATA width; must be >= IN_WIDTH; input data is zero-extended.
- ROUND_ROBIN, 1, 0 = fixed priority (index 0 highest), 1 = round robin.
- LOCK_ON_TLAST, 1, 1 = grant held from first beat until the TLAST beat is accepted; 0 = re-arbitrate every beat.
- SRC_W, max(1,$clog2(NUM_IN)), width of the source-index sideband.

Ports:
- ap_clk  in  1  sole clock, rising edge.
- ap_rst  in  1  reset; the block has one clock; reset is synchronous and active-high.
- s_axis_tdata  in  NUM_IN*IN_WIDTH  flattened inputs; input i occupies [i*IN_WIDTH +: IN_WIDTH].
- s_axis_tvalid  in  NUM_IN  per-input valid.
- s_axis_tlast  in  NUM_IN  per-input end of packet.
- s_axis_tready  out  NUM_IN  per-input ready; at most one bit high.
- m_axis_tdata  out  OUT_WIDTH  registered output data.
- m_axis_tlast  out  1  registered output TLAST.
- m_axis_tid  out  SRC_W  index of the input that supplied the beat.
- m_axis_tvalid  out  1  registered output valid.
- m_axis_tready  in  1  downstream ready.

Behaviour:
- Reset (ap_rst=1 at a clock edge):
  - m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tid all clear to 0.
  - Skid buffer empties; lock flag clears.
  - RR pointer last_grant resets to NUM_IN-1, so the first RR grant goes to index 0.
  - s_axis_tready is 0 while ap_rst is high.
  - Reset mid-packet drops buffered beats and releases the lock. No partial output is completed.
- Grant selection is combinational each cycle and only applies when not locked.
  - Fixed mode: the lowest-index valid input wins.
  - RR mode: search starts at last_grant+1, wraps modulo NUM_IN, and the first valid input wins.
  - No valid inputs means no grant and s_axis_tready is all 0.
- Locked (LOCK_ON_TLAST=1 and a beat has been accepted without TLAST):
  - The grant is forced to the locked source, even if its tvalid is low. Other inputs stall.
- s_axis_tready[g] = grant[g] & skid_empty & ~ap_rst.
  - skid_empty is a register; there is no combinational path from m_axis_tready to s_axis_tready.
- Accept = s_axis_tvalid[g] & s_axis_tready[g].
  - The accepted beat is {zero-extend(tdata_g), tlast_g, g}.
- Output stage:
  - Main register feeds m_axis_*. The skid register captures a beat accepted in the same cycle the main register is full and m_axis_tready=0.
  - skid_empty deasserts while the skid holds data.
  - On the next m_axis_tready the skid moves to the main register.
- Latency: 1 cycle from input accept to m_axis_tvalid.
- Sustained throughput: 1 beat/cycle when m_axis_tready=1.
- AXI rules:
  - m_axis_tvalid, once high, stays high with stable data until m_axis_tready is sampled high.
  - Beat order is preserved. No beat is lost or duplicated under any backpressure pattern.
- Pointer and lock update on accept only:
  - LOCK_ON_TLAST=0: last_grant <= g on every accept; lock never sets.
  - LOCK_ON_TLAST=1: a beat with tlast=0 sets lock to g; a beat with tlast=1 clears lock and sets last_grant <= g.
  - A single-beat packet (tlast=1 on the first beat) never locks.
- The lock clears and re-arbitration happens in the cycle after the TLAST beat is accepted. Back-to-back packets from different sources have no bubble.
- Fixed mode with LOCK=1: a higher-priority input arriving mid-packet waits for TLAST.

Test Plan:
- Reset then idle: all outputs 0, s_axis_tready=0000; release reset with no valids → m_axis_tvalid stays 0.
- RR, LOCK=0, all 4 inputs always valid with data 0x1000+i, m_axis_tready=1 → m_axis_tid sequence 0,1,2,3,0,… one beat/cycle; tdata 0x00001000..0x00001003.
- Fixed priority, inputs 0 and 2 valid → only input 0 served; drop input 0 valid → input 2 served next cycle, tid=2.
- LOCK=1: input 1 sends a 3-beat packet while input 0 is valid → tid=1,1,1 with tlast on the third beat, then tid=0; input 0 tready stays 0 during the packet.
- Random m_axis_tready (50%) with 1000 random beats per input → scoreboard per source: order preserved, no loss or duplication, tdata upper 16 bits zero, tvalid and data stable while stalled.
- Assert ap_rst mid-packet while the skid is full → next cycle m_axis_tvalid=0, lock cleared; the first post-reset RR grant goes to input 0.

Source files
------------

// File: rtl/axis_stream_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : axis_stream_arbiter
// Brief    : N-to-1 AXI-Stream arbiter/mux, fixed or round-robin, optional
//            TLAST packet locking, registered 2-entry skid output stage.
// Revision : 1.0
// ============================================================================
module axis_stream_arbiter #(
    parameter int NUM_IN        = 4,
    parameter int IN_WIDTH      = 16,
    parameter int OUT_WIDTH     = 32,
    parameter int ROUND_ROBIN   = 1,
    parameter int LOCK_ON_TLAST = 1,
    parameter int SRC_W         = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
    input  logic                       ap_clk,
    input  logic                       ap_rst,
    input  logic [NUM_IN*IN_WIDTH-1:0] s_axis_tdata,
    input  logic [NUM_IN-1:0]          s_axis_tvalid,
    input  logic [NUM_IN-1:0]          s_axis_tlast,
    output logic [NUM_IN-1:0]          s_axis_tready,
    output logic [OUT_WIDTH-1:0]       m_axis_tdata,
    output logic                       m_axis_tlast,
    output logic [SRC_W-1:0]           m_axis_tid,
    output logic                       m_axis_tvalid,
    input  logic                       m_axis_tready
);

    typedef struct packed {
        logic [OUT_WIDTH-1:0] data;
        logic                 last;
        logic [SRC_W-1:0]     id;
    } beat_t;

    localparam logic [SRC_W-1:0] c_LAST_IDX = SRC_W'(NUM_IN - 1);

    // Arbitration state
    logic [SRC_W-1:0]  r_last_grant;
    logic              r_locked;
    logic [SRC_W-1:0]  r_lock_src;

    // Output stage state
    beat_t             r_main;
    logic              r_main_valid;
    beat_t             r_skid;
    logic              r_skid_empty;

    // Combinational arbitration results
    logic              w_found;
    logic [SRC_W-1:0]  w_sel;
    int                w_rr_idx;
    logic [NUM_IN-1:0] w_ready;
    logic              w_accept;
    logic              w_main_free;
    beat_t             w_beat;

    // Grant selection; the descending loops leave the best candidate last.
    always_comb begin
        w_found  = 1'b0;
        w_sel    = '0;
        w_rr_idx = 0;
        if (r_locked) begin
            w_found = 1'b1;
            w_sel   = r_lock_src;
        end else if (ROUND_ROBIN == 0) begin
            for (int i = NUM_IN - 1; i >= 0; i--) begin
                if (s_axis_tvalid[i]) begin
                    w_found = 1'b1;
                    w_sel   = SRC_W'(i);
                end
            end
        end else begin
            for (int k = NUM_IN; k >= 1; k--) begin
                w_rr_idx = (int'(r_last_grant) + k) % NUM_IN;
                if (s_axis_tvalid[w_rr_idx]) begin
                    w_found = 1'b1;
                    w_sel   = SRC_W'(w_rr_idx);
                end
            end
        end
    end

    // Ready depends only on registered skid state, never on m_axis_tready.
    always_comb begin
        w_ready = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            w_ready[i] = w_found && (w_sel == SRC_W'(i)) && r_skid_empty && !ap_rst;
        end
    end

    assign w_accept    = |(s_axis_tvalid & w_ready);
    assign w_main_free = !r_main_valid || m_axis_tready;

    always_comb begin
        w_beat                     = '0;
        w_beat.data[IN_WIDTH-1:0]  = s_axis_tdata[int'(w_sel)*IN_WIDTH +: IN_WIDTH];
        w_beat.last                = s_axis_tlast[w_sel];
        w_beat.id                  = w_sel;
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_last_grant <= c_LAST_IDX;
            r_locked     <= 1'b0;
            r_lock_src   <= '0;
        end else if (w_accept) begin
            if ((LOCK_ON_TLAST != 0) && !w_beat.last) begin
                r_locked   <= 1'b1;
                r_lock_src <= w_sel;
            end else begin
                r_locked     <= 1'b0;
                r_last_grant <= w_sel;
            end
        end
    end

    // A full skid blocks new accepts, so it only ever drains into main.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_main       <= '0;
            r_main_valid <= 1'b0;
            r_skid       <= '0;
            r_skid_empty <= 1'b1;
        end else if (!r_skid_empty) begin
            if (m_axis_tready) begin
                r_main       <= r_skid;
                r_skid_empty <= 1'b1;
            end
        end else if (w_accept) begin
            if (w_main_free) begin
                r_main       <= w_beat;
                r_main_valid <= 1'b1;
            end else begin
                r_skid       <= w_beat;
                r_skid_empty <= 1'b0;
            end
        end else if (m_axis_tready) begin
            r_main_valid <= 1'b0;
        end
    end

    assign s_axis_tready = w_ready;
    assign m_axis_tdata  = r_main.data;
    assign m_axis_tlast  = r_main.last;
    assign m_axis_tid    = r_main.id;
    assign m_axis_tvalid = r_main_valid;

endmodule
`default_nettype wire
